// File: rtl/ibex_lsu_multi_outstanding.sv
// Load/store unit that keeps up to MAX_OUT bus transactions in flight, retired in order via a tracking FIFO.
// Define LSU_MISALIGNED_SPLIT_EN to split misaligned accesses in two; otherwise they raise misaligned_err_o.
module ibex_lsu_multi_outstanding #(
   parameter int MAX_OUT = 2,
   parameter int ADDR_W  = 32
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      lsu_req_i,
   output logic                      lsu_ready_o,
   input  logic                      lsu_we_i,
   input  logic [1:0]                lsu_type_i,
   input  logic                      lsu_sign_ext_i,
   input  logic [ADDR_W-1:0]         lsu_addr_i,
   input  logic [31:0]               lsu_wdata_i,
   output logic                      data_req_o,
   input  logic                      data_gnt_i,
   output logic [ADDR_W-1:0]         data_addr_o,
   output logic                      data_we_o,
   output logic [3:0]                data_be_o,
   output logic [31:0]               data_wdata_o,
   input  logic                      data_rvalid_i,
   input  logic [31:0]               data_rdata_i,
   input  logic                      data_err_i,
   input  logic                      data_pmp_err_i,
   output logic                      lsu_resp_valid_o,
   output logic [31:0]               lsu_rdata_o,
   output logic                      load_err_o,
   output logic                      store_err_o,
   output logic                      misaligned_err_o,
   output logic [$clog2(MAX_OUT):0]  outstanding_o,
   output logic                      busy_o
);
   localparam int PTR_W = $clog2(MAX_OUT);
   localparam int CNT_W = PTR_W + 1;
`ifdef LSU_MISALIGNED_SPLIT_EN
   localparam bit SPLIT_EN = 1'b1;
`else
   localparam bit SPLIT_EN = 1'b0;
`endif
   localparam logic [1:0] PART_SINGLE = 2'd0;
   localparam logic [1:0] PART_FIRST  = 2'd1;
   localparam logic [1:0] PART_SECOND = 2'd2;

   typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, ISSUE_MIS2 = 2'd2} state_t;
   typedef struct packed {
      logic [1:0] off;
      logic [1:0] typ;
      logic       sext;
      logic       we;
      logic [1:0] part;
      logic       pmp;
   } entry_t;

   state_t              r_state;
   logic                r_data_req, r_data_we;
   logic [ADDR_W-1:0]   r_data_addr;
   logic [3:0]          r_data_be;
   logic [31:0]         r_data_wdata;
   logic [ADDR_W-3:0]   r_addr_hi;
   logic [1:0]          r_off, r_type;
   logic                r_sext, r_we, r_split;
   entry_t              r_fifo [MAX_OUT];
   logic [PTR_W-1:0]    r_wptr, r_rptr;
   logic [CNT_W-1:0]    r_count;
   logic [23:0]         r_upper;
   logic                r_first_err, r_mis, r_mis_we;

   logic [1:0]          w_off, w_push_part;
   logic                w_split, w_room, w_accept, w_done, w_pop, w_fifo_resp;
   logic                w_err_now, w_err, w_resp_we, w_resp_err;
   logic [CNT_W-1:0]    w_free;
   logic [3:0]          w_be_first, w_be_second;
   logic [31:0]         w_wdata_rot, w_al, w_ext;
   logic [63:0]         w_src;
   entry_t              w_head;

   assign w_off       = lsu_addr_i[1:0];
   assign w_split     = ((lsu_type_i == 2'b00) && (w_off != 2'b00)) ||
                        ((lsu_type_i == 2'b01) && (w_off == 2'b11));
   assign w_free      = CNT_W'(MAX_OUT) - r_count;
   // Faulting split requests wait for an empty FIFO so their response never collides with a bus response.
   assign w_room      = w_split ? (SPLIT_EN ? (w_free >= CNT_W'(2)) : (r_count == '0))
                                : (w_free >= CNT_W'(1));
   assign lsu_ready_o = ~rst_i & (r_state == IDLE) & w_room;
   assign w_accept    = lsu_req_i & lsu_ready_o;
   assign w_wdata_rot = 32'({lsu_wdata_i, lsu_wdata_i} >> (6'd32 - {1'b0, w_off, 3'b000}));

   always_comb begin
      w_be_first = 4'b0000;
      case (lsu_type_i)
         2'b00:   w_be_first = 4'b1111 << w_off;
         2'b01:   w_be_first = (w_off == 2'b11) ? 4'b1000 : (4'b0011 << w_off);
         default: w_be_first = 4'b0001 << w_off;
      endcase
      w_be_second = 4'b0000;
      if (r_type == 2'b00) begin
         case (r_off)
            2'b01:   w_be_second = 4'b0001;
            2'b10:   w_be_second = 4'b0011;
            2'b11:   w_be_second = 4'b0111;
            default: w_be_second = 4'b0000;
         endcase
      end else begin
         w_be_second = 4'b0001;
      end
   end

   assign w_done      = r_data_req & (data_gnt_i | data_pmp_err_i);
   assign w_push_part = (r_state == ISSUE_MIS2) ? PART_SECOND : (r_split ? PART_FIRST : PART_SINGLE);
   // The bus must not answer in a cycle where a PMP-faulted entry (which gets no response) sits at the head.
   assign w_head      = r_fifo[r_rptr];
   assign w_pop       = (r_count != '0) & (data_rvalid_i | w_head.pmp);
   assign w_fifo_resp = w_pop & (w_head.part != PART_FIRST);
   assign w_err_now   = (data_rvalid_i & data_err_i) | w_head.pmp;
   assign w_err       = w_err_now | ((w_head.part == PART_SECOND) & r_first_err);

   // Second part: bytes of the first word sit below the new word, then shift the access down to bit 0.
   assign w_src = (w_head.part == PART_SECOND) ? {data_rdata_i, r_upper, 8'h00} : {32'h0, data_rdata_i};
   assign w_al  = 32'(w_src >> {w_head.off, 3'b000});

   always_comb begin
      w_ext = w_al;
      case (w_head.typ)
         2'b00:   w_ext = w_al;
         2'b01:   w_ext = {{16{w_head.sext & w_al[15]}}, w_al[15:0]};
         default: w_ext = {{24{w_head.sext & w_al[7]}}, w_al[7:0]};
      endcase
   end

   assign w_resp_we        = w_fifo_resp ? w_head.we : r_mis_we;
   assign w_resp_err       = w_fifo_resp ? w_err : r_mis;
   assign lsu_resp_valid_o = w_fifo_resp | r_mis;
   assign lsu_rdata_o      = (w_fifo_resp & ~w_head.we) ? w_ext : 32'h0;
   assign load_err_o       = lsu_resp_valid_o & w_resp_err & ~w_resp_we;
   assign store_err_o      = lsu_resp_valid_o & w_resp_err & w_resp_we;
   assign misaligned_err_o = SPLIT_EN ? 1'b0 : r_mis;
   assign data_req_o       = r_data_req;
   assign data_addr_o      = r_data_addr;
   assign data_we_o        = r_data_we;
   assign data_be_o        = r_data_be;
   assign data_wdata_o     = r_data_wdata;
   assign outstanding_o    = r_count;
   assign busy_o           = (r_state != IDLE) | (r_count != '0);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= IDLE;         r_data_req <= 1'b0;   r_data_we <= 1'b0;
         r_data_addr <= '0;       r_data_be <= 4'b0;    r_data_wdata <= 32'h0;
         r_addr_hi <= '0;         r_off <= 2'b0;        r_type <= 2'b0;
         r_sext <= 1'b0;          r_we <= 1'b0;         r_split <= 1'b0;
         r_wptr <= '0;            r_rptr <= '0;         r_count <= '0;
         r_upper <= 24'h0;        r_first_err <= 1'b0;  r_mis <= 1'b0;
         r_mis_we <= 1'b0;
      end else begin
         r_mis <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_addr_hi <= lsu_addr_i[ADDR_W-1:2];
                  r_off     <= w_off;
                  r_type    <= lsu_type_i;
                  r_sext    <= lsu_sign_ext_i;
                  r_we      <= lsu_we_i;
                  r_split   <= w_split & SPLIT_EN;
                  if (w_split && !SPLIT_EN) begin
                     r_mis    <= 1'b1;
                     r_mis_we <= lsu_we_i;
                  end else begin
                     r_state      <= ISSUE;
                     r_data_req   <= 1'b1;
                     r_data_addr  <= {lsu_addr_i[ADDR_W-1:2], 2'b00};
                     r_data_we    <= lsu_we_i;
                     r_data_be    <= w_be_first;
                     r_data_wdata <= w_wdata_rot;
                  end
               end
            end
            ISSUE: begin
               if (w_done) begin
                  if (r_split) begin
                     r_state     <= ISSUE_MIS2;
                     r_data_addr <= {r_addr_hi + (ADDR_W-2)'(1), 2'b00};
                     r_data_be   <= w_be_second;
                  end else begin
                     r_state    <= IDLE;
                     r_data_req <= 1'b0;
                  end
               end
            end
            ISSUE_MIS2: begin
               if (w_done) begin
                  r_state    <= IDLE;
                  r_data_req <= 1'b0;
               end
            end
            default: r_state <= IDLE;
         endcase
         if (w_done) r_wptr <= r_wptr + PTR_W'(1);
         if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
         r_count <= r_count + CNT_W'(w_done) - CNT_W'(w_pop);
         if (w_pop && (w_head.part == PART_FIRST)) begin
            r_upper     <= data_rdata_i[31:8];
            r_first_err <= w_err_now;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (w_done) r_fifo[r_wptr] <= '{off: r_off, typ: r_type, sext: r_sext, we: r_we,
                                     part: w_push_part, pmp: data_pmp_err_i};
   end
endmodule

// File: tb/tb_ibex_lsu_multi_outstanding.sv
// Directed bench for ibex_lsu_multi_outstanding (MAX_OUT=2); honours LSU_MISALIGNED_SPLIT_EN like the design.
module tb_ibex_lsu_multi_outstanding;
   logic clk_i = 1'b0;
   logic rst_i;
   logic lsu_req_i, lsu_ready_o, lsu_we_i, lsu_sign_ext_i;
   logic [1:0] lsu_type_i;
   logic [31:0] lsu_addr_i, lsu_wdata_i;
   logic data_req_o, data_gnt_i, data_we_o, data_rvalid_i, data_err_i, data_pmp_err_i;
   logic [31:0] data_addr_o, data_wdata_o, data_rdata_i, lsu_rdata_o;
   logic [3:0] data_be_o;
   logic lsu_resp_valid_o, load_err_o, store_err_o, misaligned_err_o, busy_o;
   logic [1:0] outstanding_o;

   int errors = 0;
   int checks = 0;
   logic ob_rdy, ob_req, ob_v, ob_le, ob_se;
   logic [31:0] ob_addr, ob_wd, ob_rd;
   logic [3:0] ob_be;

   always #5 clk_i = ~clk_i;

   ibex_lsu_multi_outstanding #(.MAX_OUT(2), .ADDR_W(32)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .lsu_req_i(lsu_req_i), .lsu_ready_o(lsu_ready_o),
      .lsu_we_i(lsu_we_i), .lsu_type_i(lsu_type_i), .lsu_sign_ext_i(lsu_sign_ext_i),
      .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i), .data_req_o(data_req_o),
      .data_gnt_i(data_gnt_i), .data_addr_o(data_addr_o), .data_we_o(data_we_o),
      .data_be_o(data_be_o), .data_wdata_o(data_wdata_o), .data_rvalid_i(data_rvalid_i),
      .data_rdata_i(data_rdata_i), .data_err_i(data_err_i), .data_pmp_err_i(data_pmp_err_i),
      .lsu_resp_valid_o(lsu_resp_valid_o), .lsu_rdata_o(lsu_rdata_o), .load_err_o(load_err_o),
      .store_err_o(store_err_o), .misaligned_err_o(misaligned_err_o),
      .outstanding_o(outstanding_o), .busy_o(busy_o)
   );

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle_inputs();
      lsu_req_i = 0; lsu_we_i = 0; lsu_type_i = 2'b00; lsu_sign_ext_i = 0;
      lsu_addr_i = 32'h0; lsu_wdata_i = 32'h0; data_gnt_i = 0; data_rvalid_i = 0;
      data_rdata_i = 32'h0; data_err_i = 0; data_pmp_err_i = 0;
   endtask

   // Presents one request, then completes its bus phase with a grant or a PMP fault.
   task automatic issue(input logic we, input logic [1:0] typ, input logic sext,
                        input logic [31:0] addr, input logic [31:0] wd, input logic pmp);
      lsu_req_i = 1; lsu_we_i = we; lsu_type_i = typ; lsu_sign_ext_i = sext;
      lsu_addr_i = addr; lsu_wdata_i = wd;
      #1 ob_rdy = lsu_ready_o;
      tick();
      lsu_req_i = 0;
      #1 ob_req = data_req_o; ob_addr = data_addr_o; ob_be = data_be_o; ob_wd = data_wdata_o;
      if (pmp) data_pmp_err_i = 1; else data_gnt_i = 1;
      tick();
      data_gnt_i = 0; data_pmp_err_i = 0;
   endtask

   task automatic respond(input logic [31:0] d, input logic e);
      data_rvalid_i = 1; data_rdata_i = d; data_err_i = e;
      #1 ob_v = lsu_resp_valid_o; ob_rd = lsu_rdata_o; ob_le = load_err_o; ob_se = store_err_o;
      tick();
      data_rvalid_i = 0; data_err_i = 0; data_rdata_i = 32'h0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_i = 1;
      lsu_req_i = 1; data_gnt_i = 1; data_rvalid_i = 1; data_rdata_i = 32'hFFFF_FFFF;
      tick(); tick();
      checks++; if (lsu_ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", lsu_ready_o); end
      checks++; if (data_req_o !== 1'b0) begin errors++; $display("FAIL reset_data_req: got %b want 0", data_req_o); end
      checks++; if (outstanding_o !== 2'd0) begin errors++; $display("FAIL reset_outstanding: got %0d want 0", outstanding_o); end
      checks++; if ({lsu_resp_valid_o, load_err_o, store_err_o, misaligned_err_o, busy_o} !== 5'b0) begin
         errors++; $display("FAIL reset_strobes: got %b want 00000",
                            {lsu_resp_valid_o, load_err_o, store_err_o, misaligned_err_o, busy_o}); end
      checks++; if (lsu_rdata_o !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", lsu_rdata_o); end
      idle_inputs();
      tick();
      rst_i = 0;
      tick();
   endtask

   task automatic test_aligned_load();
      issue(0, 2'b00, 0, 32'h0000_0100, 32'h0, 0);
      checks++; if (ob_rdy !== 1'b1) begin errors++; $display("FAIL aligned_ready: got %b want 1", ob_rdy); end
      checks++; if (ob_req !== 1'b1 || ob_addr !== 32'h100) begin errors++;
         $display("FAIL aligned_req: got req=%b addr=%h want req=1 addr=00000100", ob_req, ob_addr); end
      checks++; if (ob_be !== 4'b1111) begin errors++; $display("FAIL aligned_be: got %b want 1111", ob_be); end
      #1;
      checks++; if (outstanding_o !== 2'd1 || data_req_o !== 1'b0) begin errors++;
         $display("FAIL aligned_pending: got out=%0d req=%b want out=1 req=0", outstanding_o, data_req_o); end
      tick();
      respond(32'hDEAD_BEEF, 0);
      checks++; if (ob_v !== 1'b1 || ob_rd !== 32'hDEAD_BEEF) begin errors++;
         $display("FAIL aligned_resp: got v=%b rdata=%h want v=1 rdata=deadbeef", ob_v, ob_rd); end
      checks++; if (ob_le !== 1'b0 || ob_se !== 1'b0) begin errors++;
         $display("FAIL aligned_err: got le=%b se=%b want 0 0", ob_le, ob_se); end
      #1;
      checks++; if (lsu_resp_valid_o !== 1'b0 || outstanding_o !== 2'd0 || busy_o !== 1'b0) begin errors++;
         $display("FAIL aligned_after: got v=%b out=%0d busy=%b want 0 0 0", lsu_resp_valid_o, outstanding_o, busy_o); end
   endtask

   task automatic test_back_to_back();
      issue(0, 2'b00, 0, 32'h0000_0200, 32'h0, 0);
      issue(0, 2'b00, 0, 32'h0000_0204, 32'h0, 0);
      checks++; if (ob_rdy !== 1'b1 || ob_addr !== 32'h204) begin errors++;
         $display("FAIL b2b_second_issue: got rdy=%b addr=%h want rdy=1 addr=00000204", ob_rdy, ob_addr); end
      #1;
      checks++; if (outstanding_o !== 2'd2 || lsu_ready_o !== 1'b0) begin errors++;
         $display("FAIL b2b_full: got out=%0d ready=%b want out=2 ready=0", outstanding_o, lsu_ready_o); end
      respond(32'h1111_0000, 0);
      checks++; if (ob_v !== 1'b1 || ob_rd !== 32'h1111_0000) begin errors++;
         $display("FAIL b2b_resp1: got v=%b rdata=%h want v=1 rdata=11110000", ob_v, ob_rd); end
      #1;
      checks++; if (outstanding_o !== 2'd1 || lsu_ready_o !== 1'b1) begin errors++;
         $display("FAIL b2b_one_left: got out=%0d ready=%b want out=1 ready=1", outstanding_o, lsu_ready_o); end
      lsu_addr_i = 32'h0000_0203;
      #1;
      checks++; if (lsu_ready_o !== 1'b0) begin errors++;
         $display("FAIL b2b_split_room: got ready=%b want 0", lsu_ready_o); end
      lsu_addr_i = 32'h0000_0204;
      respond(32'h2222_0000, 0);
      checks++; if (ob_v !== 1'b1 || ob_rd !== 32'h2222_0000) begin errors++;
         $display("FAIL b2b_resp2: got v=%b rdata=%h want v=1 rdata=22220000", ob_v, ob_rd); end
      #1;
      checks++; if (outstanding_o !== 2'd0 || busy_o !== 1'b0) begin errors++;
         $display("FAIL b2b_drained: got out=%0d busy=%b want 0 0", outstanding_o, busy_o); end
   endtask

   task automatic test_formats();
      issue(0, 2'b01, 1, 32'h0000_0102, 32'h0, 0);
      checks++; if (ob_be !== 4'b1100 || ob_addr !== 32'h100) begin errors++;
         $display("FAIL half_be: got be=%b addr=%h want be=1100 addr=00000100", ob_be, ob_addr); end
      respond(32'h8001_0000, 0);
      checks++; if (ob_rd !== 32'hFFFF_8001) begin errors++; $display("FAIL half_signed: got %h want ffff8001", ob_rd); end
      issue(0, 2'b01, 0, 32'h0000_0102, 32'h0, 0);
      respond(32'h8001_0000, 0);
      checks++; if (ob_rd !== 32'h0000_8001) begin errors++; $display("FAIL half_unsigned: got %h want 00008001", ob_rd); end
      issue(0, 2'b10, 1, 32'h0000_0101, 32'h0, 0);
      checks++; if (ob_be !== 4'b0010) begin errors++; $display("FAIL byte_be: got %b want 0010", ob_be); end
      respond(32'h0000_8000, 0);
      checks++; if (ob_rd !== 32'hFFFF_FF80) begin errors++; $display("FAIL byte_signed: got %h want ffffff80", ob_rd); end
      issue(0, 2'b01, 0, 32'h0000_0101, 32'h0, 0);
      checks++; if (ob_be !== 4'b0110) begin errors++; $display("FAIL half_off1_be: got %b want 0110", ob_be); end
      respond(32'hAABB_CCDD, 0);
      checks++; if (ob_rd !== 32'h0000_BBCC) begin errors++; $display("FAIL half_off1_data: got %h want 0000bbcc", ob_rd); end
      issue(1, 2'b10, 0, 32'h0000_0103, 32'h0000_00AB, 0);
      checks++; if (ob_be !== 4'b1000 || ob_wd !== 32'hAB00_0000) begin errors++;
         $display("FAIL byte_store: got be=%b wdata=%h want be=1000 wdata=ab000000", ob_be, ob_wd); end
      respond(32'h1234_5678, 0);
      checks++; if (ob_v !== 1'b1 || ob_rd !== 32'h0 || ob_se !== 1'b0) begin errors++;
         $display("FAIL store_resp: got v=%b rdata=%h se=%b want 1 00000000 0", ob_v, ob_rd, ob_se); end
      issue(1, 2'b01, 0, 32'h0000_0102, 32'h0000_1234, 0);
      checks++; if (ob_be !== 4'b1100 || ob_wd !== 32'h1234_0000) begin errors++;
         $display("FAIL half_store: got be=%b wdata=%h want be=1100 wdata=12340000", ob_be, ob_wd); end
      respond(32'h0, 1);
      checks++; if (ob_se !== 1'b1 || ob_le !== 1'b0) begin errors++;
         $display("FAIL store_bus_err: got se=%b le=%b want se=1 le=0", ob_se, ob_le); end
   endtask

   task automatic test_pmp();
      issue(1, 2'b00, 0, 32'h0000_0300, 32'hCAFE_F00D, 1);
      #1;
      checks++; if (lsu_resp_valid_o !== 1'b1 || store_err_o !== 1'b1 || load_err_o !== 1'b0) begin errors++;
         $display("FAIL pmp_store: got v=%b se=%b le=%b want 1 1 0", lsu_resp_valid_o, store_err_o, load_err_o); end
      tick();
      checks++; if (lsu_resp_valid_o !== 1'b0 || outstanding_o !== 2'd0) begin errors++;
         $display("FAIL pmp_retired: got v=%b out=%0d want 0 0", lsu_resp_valid_o, outstanding_o); end
      issue(0, 2'b00, 0, 32'h0000_0304, 32'h0, 1);
      #1;
      checks++; if (lsu_resp_valid_o !== 1'b1 || load_err_o !== 1'b1 || store_err_o !== 1'b0) begin errors++;
         $display("FAIL pmp_load: got v=%b le=%b se=%b want 1 1 0", lsu_resp_valid_o, load_err_o, store_err_o); end
      tick();
   endtask

`ifdef LSU_MISALIGNED_SPLIT_EN
   task automatic test_split();
      lsu_req_i = 1; lsu_we_i = 0; lsu_type_i = 2'b00; lsu_sign_ext_i = 0; lsu_addr_i = 32'h0000_0103;
      tick();
      lsu_req_i = 0;
      #1;
      checks++; if (data_addr_o !== 32'h100 || data_be_o !== 4'b1000) begin errors++;
         $display("FAIL split_part1: got addr=%h be=%b want 00000100 1000", data_addr_o, data_be_o); end
      data_gnt_i = 1;
      tick();
      checks++; if (data_req_o !== 1'b1 || data_addr_o !== 32'h104 || data_be_o !== 4'b0111) begin errors++;
         $display("FAIL split_part2: got req=%b addr=%h be=%b want 1 00000104 0111", data_req_o, data_addr_o, data_be_o); end
      tick();
      data_gnt_i = 0;
      respond(32'h1122_3344, 0);
      checks++; if (ob_v !== 1'b0) begin errors++; $display("FAIL split_first_quiet: got v=%b want 0", ob_v); end
      respond(32'h5566_7788, 0);
      checks++; if (ob_v !== 1'b1 || ob_rd !== 32'h6677_8811 || ob_le !== 1'b0) begin errors++;
         $display("FAIL split_word: got v=%b rdata=%h le=%b want 1 66778811 0", ob_v, ob_rd, ob_le); end
      lsu_req_i = 1; lsu_type_i = 2'b01; lsu_addr_i = 32'hFFFF_FFFF;
      tick();
      lsu_req_i = 0; data_gnt_i = 1;
      tick();
      checks++; if (data_addr_o !== 32'h0 || data_be_o !== 4'b0001) begin errors++;
         $display("FAIL split_wrap: got addr=%h be=%b want 00000000 0001", data_addr_o, data_be_o); end
      tick();
      data_gnt_i = 0;
      respond(32'hAB00_0000, 1);
      respond(32'h0000_00CD, 0);
      checks++; if (ob_v !== 1'b1 || ob_rd !== 32'h0000_CDAB || ob_le !== 1'b1) begin errors++;
         $display("FAIL split_half_err: got v=%b rdata=%h le=%b want 1 0000cdab 1", ob_v, ob_rd, ob_le); end
   endtask
`else
   task automatic test_misaligned();
      lsu_req_i = 1; lsu_we_i = 0; lsu_type_i = 2'b00; lsu_addr_i = 32'h0000_0103;
      #1;
      checks++; if (lsu_ready_o !== 1'b1) begin errors++; $display("FAIL mis_ready: got %b want 1", lsu_ready_o); end
      tick();
      lsu_req_i = 0;
      #1;
      checks++; if (data_req_o !== 1'b0 || misaligned_err_o !== 1'b1 || lsu_resp_valid_o !== 1'b1) begin errors++;
         $display("FAIL mis_load_pulse: got req=%b mis=%b v=%b want 0 1 1", data_req_o, misaligned_err_o, lsu_resp_valid_o); end
      checks++; if (load_err_o !== 1'b1 || store_err_o !== 1'b0) begin errors++;
         $display("FAIL mis_load_err: got le=%b se=%b want 1 0", load_err_o, store_err_o); end
      tick();
      checks++; if (misaligned_err_o !== 1'b0 || lsu_resp_valid_o !== 1'b0 || data_req_o !== 1'b0) begin errors++;
         $display("FAIL mis_one_shot: got mis=%b v=%b req=%b want 0 0 0", misaligned_err_o, lsu_resp_valid_o, data_req_o); end
      lsu_req_i = 1; lsu_we_i = 1; lsu_type_i = 2'b01; lsu_addr_i = 32'h0000_0203;
      tick();
      lsu_req_i = 0;
      #1;
      checks++; if (misaligned_err_o !== 1'b1 || store_err_o !== 1'b1 || load_err_o !== 1'b0) begin errors++;
         $display("FAIL mis_store: got mis=%b se=%b le=%b want 1 1 0", misaligned_err_o, store_err_o, load_err_o); end
      tick();
   endtask
`endif

   task automatic test_reset_mid();
      issue(0, 2'b00, 0, 32'h0000_0400, 32'h0, 0);
      issue(0, 2'b00, 0, 32'h0000_0404, 32'h0, 0);
      #1;
      checks++; if (outstanding_o !== 2'd2) begin errors++; $display("FAIL rstmid_before: got %0d want 2", outstanding_o); end
      rst_i = 1;
      #1;
      checks++; if (outstanding_o !== 2'd0 || busy_o !== 1'b0 || lsu_ready_o !== 1'b0) begin errors++;
         $display("FAIL rstmid_cleared: got out=%0d busy=%b ready=%b want 0 0 0", outstanding_o, busy_o, lsu_ready_o); end
      tick();
      rst_i = 0;
      tick();
      for (int i = 0; i < 2; i++) begin
         respond(32'h5A5A_5A5A, 0);
         checks++; if (ob_v !== 1'b0) begin errors++; $display("FAIL rstmid_stray_%0d: got v=%b want 0", i, ob_v); end
      end
      #1;
      checks++; if (outstanding_o !== 2'd0) begin errors++; $display("FAIL rstmid_after: got %0d want 0", outstanding_o); end
   endtask

   initial begin
      test_reset();
      test_aligned_load();
      tick();
      test_back_to_back();
      tick();
      test_formats();
      tick();
      test_pmp();
`ifdef LSU_MISALIGNED_SPLIT_EN
      test_split();
`else
      test_misaligned();
`endif
      tick();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
